// File: rtl/key_event_poller.sv
// key_event_poller: Avalon-MM initiator that polls a push-button PIO edge-capture register.
// Optional KEY_POLL_IRQ_EN: unmask the PIO interrupt after reset and poll immediately on irq.
module key_event_poller #(
    parameter int unsigned POLL_INTERVAL = 50000,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             irq,
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [31:0]      avm_writedata,
    input  logic [31:0]      avm_readdata,
    output logic             event_pulse,
    output logic [CNT_W-1:0] event_count,
    output logic             busy
);

    localparam int unsigned TMR_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(POLL_INTERVAL - 1);

    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    // ST_RST is the busy, bus-idle state held during reset; it leaves on the first clock.
    typedef enum logic [2:0] {
        ST_RST  = 3'd0,
        ST_IDLE = 3'd1,
        ST_RD   = 3'd2,
        ST_CAP  = 3'd3,
        ST_CLR  = 3'd4
`ifdef KEY_POLL_IRQ_EN
        , ST_INIT = 3'd5
`endif
    } state_e;

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             timer_hit;
    logic             poll_now;

    logic [1:0]       address_q, address_d;
    logic             cs_q, cs_d;
    logic             write_n_q, write_n_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             busy_q, busy_d;

    assign timer_hit = (timer_q == TMR_LAST);

`ifdef KEY_POLL_IRQ_EN
    assign poll_now = timer_hit || irq;
    logic unused_rdata;
    assign unused_rdata = ^avm_readdata[31:1];
`else
    assign poll_now = timer_hit;
    logic unused_inputs;
    assign unused_inputs = ^{irq, avm_readdata[31:1]};
`endif

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_RST;
            timer_q   <= '0;
            address_q <= '0;
            cs_q      <= 1'b0;
            write_n_q <= 1'b1;
            wdata_q   <= '0;
            pulse_q   <= 1'b0;
            count_q   <= '0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            address_q <= address_d;
            cs_q      <= cs_d;
            write_n_q <= write_n_d;
            wdata_q   <= wdata_d;
            pulse_q   <= pulse_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
        end
    end

    // Next state and poll timer. The timer only runs in IDLE with enable high.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            ST_RST: begin
`ifdef KEY_POLL_IRQ_EN
                state_d = ST_INIT;
`else
                state_d = ST_IDLE;
`endif
                timer_d = '0;
            end
`ifdef KEY_POLL_IRQ_EN
            ST_INIT: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
`endif
            ST_IDLE: begin
                if (!enable) begin
                    timer_d = '0;
                end else if (poll_now) begin
                    timer_d = '0;
                    state_d = ST_RD;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_RD: begin
                state_d = ST_CAP;
            end
            ST_CAP: begin
                // PIO read data is registered, so it is valid one cycle after RD.
                state_d = avm_readdata[0] ? ST_CLR : ST_IDLE;
            end
            ST_CLR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registers line up with the state.
    always_comb begin
        address_d = '0;
        cs_d      = 1'b0;
        write_n_d = 1'b1;
        wdata_d   = '0;
        case (state_d)
`ifdef KEY_POLL_IRQ_EN
            ST_INIT: begin
                address_d = ADDR_MASK;
                cs_d      = 1'b1;
                write_n_d = 1'b0;
                wdata_d   = 32'd1;
            end
`endif
            ST_RD: begin
                address_d = ADDR_EDGE;
                cs_d      = 1'b1;
            end
            ST_CLR: begin
                address_d = ADDR_EDGE;
                cs_d      = 1'b1;
                write_n_d = 1'b0;
            end
            default: begin
                address_d = '0;
            end
        endcase
        busy_d  = (state_d != ST_IDLE);
        pulse_d = (state_q == ST_CLR);
        count_d = pulse_d ? count_q + CNT_W'(1) : count_q;
    end

`ifndef KEY_POLL_IRQ_EN
    logic unused_mask_addr;
    assign unused_mask_addr = ^ADDR_MASK;
`endif

    assign avm_address    = address_q;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = write_n_q;
    assign avm_writedata  = wdata_q;
    assign event_pulse    = pulse_q;
    assign event_count    = count_q;
    assign busy           = busy_q;

    // Every bus access is a single-cycle strobe.
    assert property (@(posedge clk) disable iff (!reset_n) avm_chipselect |=> !avm_chipselect);

endmodule

// File: tb/tb_key_event_poller.sv
// Bench for key_event_poller: PIO responder model, bus/event scoreboards and scenario tasks.
`timescale 1ns/1ps
module tb_key_event_poller;

    localparam int unsigned POLL = 4;
    localparam int unsigned CW   = 2;
    localparam int unsigned TW   = 35;

    localparam logic [TW-1:0] TXN_RD   = {1'b0, 2'd3, 32'h0};
    localparam logic [TW-1:0] TXN_CLR  = {1'b1, 2'd3, 32'h0};
    localparam logic [TW-1:0] TXN_MASK = {1'b1, 2'd2, 32'h1};

    logic          clk;
    logic          reset_n;
    logic          enable;
    logic          irq;
    logic [1:0]    avm_address;
    logic          avm_chipselect;
    logic          avm_write_n;
    logic [31:0]   avm_writedata;
    logic [31:0]   avm_readdata;
    logic          event_pulse;
    logic [CW-1:0] event_count;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    logic [TW-1:0] exp_q[$];
    logic [CW-1:0] ev_q[$];
    logic [CW-1:0] exp_cnt;

    logic cap_q;
    logic set_cap;
    logic prev_cs;
    logic prev_pulse;

    key_event_poller #(
        .POLL_INTERVAL(POLL),
        .CNT_W        (CW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .irq           (irq),
        .avm_address   (avm_address),
        .avm_chipselect(avm_chipselect),
        .avm_write_n   (avm_write_n),
        .avm_writedata (avm_writedata),
        .avm_readdata  (avm_readdata),
        .event_pulse   (event_pulse),
        .event_count   (event_count),
        .busy          (busy)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // PIO responder: edge-capture bit, clear wins over a simultaneous edge, noisy upper bits.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_q        <= 1'b0;
            avm_readdata <= '0;
        end else begin
            if (avm_chipselect && avm_write_n && avm_address == 2'd3)
                avm_readdata <= ($urandom() & 32'hFFFF_FFFE) | {31'd0, cap_q};
            else
                avm_readdata <= $urandom();
            if (avm_chipselect && !avm_write_n && avm_address == 2'd3)
                cap_q <= 1'b0;
            else if (set_cap)
                cap_q <= 1'b1;
        end
    end

    // Bus scoreboard.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_cs <= 1'b0;
        end else begin
            if (avm_chipselect) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL bus_unexpected: got access %h, required none",
                             {~avm_write_n, avm_address, avm_write_n ? 32'h0 : avm_writedata});
                end else begin
                    logic [TW-1:0] exp_txn;
                    exp_txn = exp_q.pop_front();
                    if ({~avm_write_n, avm_address, avm_write_n ? 32'h0 : avm_writedata} !== exp_txn) begin
                        failures++;
                        $display("FAIL bus_access: got %h, required %h",
                                 {~avm_write_n, avm_address, avm_write_n ? 32'h0 : avm_writedata}, exp_txn);
                    end
                end
                checks++;
                if (prev_cs !== 1'b0) begin
                    failures++;
                    $display("FAIL cs_single_cycle: chipselect high on consecutive cycles, required one cycle");
                end
            end
            prev_cs <= avm_chipselect;
        end
    end

    // Event scoreboard.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_pulse <= 1'b0;
        end else begin
            if (event_pulse) begin
                checks++;
                if (ev_q.size() == 0) begin
                    failures++;
                    $display("FAIL event_unexpected: got pulse with count %0d, required no pulse", event_count);
                end else begin
                    logic [CW-1:0] exp_c;
                    exp_c = ev_q.pop_front();
                    if (event_count !== exp_c) begin
                        failures++;
                        $display("FAIL event_count: got %0d, required %0d", event_count, exp_c);
                    end
                end
                checks++;
                if (prev_pulse !== 1'b0) begin
                    failures++;
                    $display("FAIL pulse_width: event_pulse high two cycles, required one");
                end
            end
            prev_pulse <= event_pulse;
        end
    end

    // Driver tasks.
    task automatic wait_cs(input bit want_write, input int budget, output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (cycles < budget && !ok) begin
            @(negedge clk);
            cycles++;
            if (avm_chipselect && (avm_write_n == !want_write))
                ok = 1'b1;
        end
    endtask

    task automatic wait_pulse(input int budget, output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (cycles < budget && !ok) begin
            @(negedge clk);
            cycles++;
            if (event_pulse)
                ok = 1'b1;
        end
    endtask

    task automatic pulse_cap;
        set_cap = 1'b1;
        @(negedge clk);
        set_cap = 1'b0;
    endtask

    task automatic expect_capture;
        exp_q.push_back(TXN_RD);
        exp_q.push_back(TXN_CLR);
        exp_cnt = exp_cnt + 1'b1;
        ev_q.push_back(exp_cnt);
    endtask

    // Scenarios.
    task automatic test_reset;
        reset_n = 1'b0;
        enable  = 1'b0;
        irq     = 1'b0;
        set_cap = 1'b0;
        exp_cnt = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({avm_address, avm_chipselect, avm_write_n, avm_writedata} !== {2'd0, 1'b0, 1'b1, 32'd0}) begin
            failures++;
            $display("FAIL reset_bus: got addr=%0d cs=%b wn=%b wd=%h, required 0 0 1 0",
                     avm_address, avm_chipselect, avm_write_n, avm_writedata);
        end
        checks++;
        if ({event_pulse, event_count, busy} !== {1'b0, {CW{1'b0}}, 1'b1}) begin
            failures++;
            $display("FAIL reset_status: got pulse=%b count=%0d busy=%b, required 0 0 1",
                     event_pulse, event_count, busy);
        end
`ifdef KEY_POLL_IRQ_EN
        exp_q.push_back(TXN_MASK);
`endif
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_exit_idle: got busy=%b, required 0", busy);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL init_write: got %0d pending accesses, required 0", exp_q.size());
        end
    endtask

    task automatic test_periodic_poll;
        int cyc;
        bit ok;
        repeat (3) exp_q.push_back(TXN_RD);
        enable = 1'b1;
        wait_cs(1'b0, 50, cyc, ok);
        checks++;
        if (!ok || cyc != POLL) begin
            failures++;
            $display("FAIL first_poll_latency: got %0d cycles (ok=%b), required %0d", cyc, ok, POLL);
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_in_rd: got %b, required 1", busy);
        end
        for (int i = 0; i < 2; i++) begin
            wait_cs(1'b0, 50, cyc, ok);
            checks++;
            if (!ok || cyc != POLL + 2) begin
                failures++;
                $display("FAIL poll_period_idle: got %0d cycles (ok=%b), required %0d", cyc, ok, POLL + 2);
            end
        end
        checks++;
        if (event_count !== exp_cnt) begin
            failures++;
            $display("FAIL count_no_capture: got %0d, required %0d", event_count, exp_cnt);
        end
    endtask

    task automatic test_capture;
        int cyc;
        int total;
        bit ok;
        pulse_cap();
        expect_capture();
        wait_cs(1'b0, 50, cyc, ok);
        checks++;
        if (!ok || cyc + 1 != POLL + 2) begin
            failures++;
            $display("FAIL capture_poll_period: got %0d cycles (ok=%b), required %0d", cyc + 1, ok, POLL + 2);
        end
        wait_cs(1'b1, 10, cyc, ok);
        total = cyc;
        checks++;
        if (!ok || cyc != 2) begin
            failures++;
            $display("FAIL clear_after_read: got %0d cycles (ok=%b), required 2", cyc, ok);
        end
        wait_pulse(10, cyc, ok);
        total += cyc;
        checks++;
        if (!ok || cyc != 1) begin
            failures++;
            $display("FAIL pulse_after_clear: got %0d cycles (ok=%b), required 1", cyc, ok);
        end
        exp_q.push_back(TXN_RD);
        exp_q.push_back(TXN_RD);
        wait_cs(1'b0, 50, cyc, ok);
        total += cyc;
        checks++;
        if (!ok || total != POLL + 3) begin
            failures++;
            $display("FAIL poll_period_capture: got %0d cycles (ok=%b), required %0d", total, ok, POLL + 3);
        end
        wait_cs(1'b0, 50, cyc, ok);
        checks++;
        if (!ok || cyc != POLL + 2) begin
            failures++;
            $display("FAIL poll_after_clear: got %0d cycles (ok=%b), required %0d", cyc, ok, POLL + 2);
        end
    endtask

    task automatic test_count_wrap;
        int cyc;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            pulse_cap();
            expect_capture();
            wait_cs(1'b1, 40, cyc, ok);
            wait_pulse(10, cyc, ok);
            checks++;
            if (!ok || event_count !== exp_cnt) begin
                failures++;
                $display("FAIL count_wrap: got %0d (ok=%b), required %0d", event_count, ok, exp_cnt);
            end
        end
    endtask

    task automatic test_random_polls;
        int cyc;
        bit ok;
        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                pulse_cap();
                expect_capture();
                wait_pulse(40, cyc, ok);
                checks++;
                if (!ok || event_count !== exp_cnt) begin
                    failures++;
                    $display("FAIL random_capture: got %0d (ok=%b), required %0d", event_count, ok, exp_cnt);
                end
            end else begin
                exp_q.push_back(TXN_RD);
                wait_cs(1'b0, 40, cyc, ok);
                checks++;
                if (!ok) begin
                    failures++;
                    $display("FAIL random_poll: no read within 40 cycles, required a read");
                end
            end
        end
    endtask

    task automatic test_enable_drop;
        int cyc;
        int strobes;
        bit ok;
        pulse_cap();
        expect_capture();
        wait_cs(1'b0, 40, cyc, ok);
        enable = 1'b0;
        wait_cs(1'b1, 10, cyc, ok);
        checks++;
        if (!ok || cyc != 2) begin
            failures++;
            $display("FAIL drop_clear_completes: got %0d cycles (ok=%b), required 2", cyc, ok);
        end
        wait_pulse(10, cyc, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL drop_pulse: no pulse, required one");
        end
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (avm_chipselect) strobes++;
        end
        checks++;
        if (strobes != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL disabled_idle: got %0d strobes busy=%b, required 0 strobes busy=0", strobes, busy);
        end
        exp_q.push_back(TXN_RD);
        enable = 1'b1;
        wait_cs(1'b0, 50, cyc, ok);
        checks++;
        if (!ok || cyc != POLL) begin
            failures++;
            $display("FAIL timer_restart: got %0d cycles (ok=%b), required %0d", cyc, ok, POLL);
        end
    endtask

    task automatic test_irq;
        int cyc;
        int exp_gap;
        bit ok;
`ifdef KEY_POLL_IRQ_EN
        exp_gap = 4;
`else
        exp_gap = POLL + 2;
`endif
        repeat (3) @(negedge clk);
        irq = 1'b1;
        exp_q.push_back(TXN_RD);
        wait_cs(1'b0, 40, cyc, ok);
        irq = 1'b0;
        checks++;
        if (!ok || cyc + 3 != exp_gap) begin
            failures++;
            $display("FAIL irq_poll: got %0d cycles (ok=%b), required %0d", cyc + 3, ok, exp_gap);
        end
        exp_q.push_back(TXN_RD);
        wait_cs(1'b0, 40, cyc, ok);
        checks++;
        if (!ok || cyc != POLL + 2) begin
            failures++;
            $display("FAIL irq_timer_cleared: got %0d cycles (ok=%b), required %0d", cyc, ok, POLL + 2);
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        bit ok;
        pulse_cap();
        exp_q.push_back(TXN_RD);
        exp_q.push_back(TXN_CLR);
        wait_cs(1'b1, 40, cyc, ok);
        #2;
        reset_n = 1'b0;
        enable  = 1'b0;
        #1;
        checks++;
        if ({avm_address, avm_chipselect, avm_write_n, avm_writedata} !== {2'd0, 1'b0, 1'b1, 32'd0}) begin
            failures++;
            $display("FAIL midreset_bus: got addr=%0d cs=%b wn=%b wd=%h, required 0 0 1 0",
                     avm_address, avm_chipselect, avm_write_n, avm_writedata);
        end
        checks++;
        if ({event_pulse, event_count, busy} !== {1'b0, {CW{1'b0}}, 1'b1}) begin
            failures++;
            $display("FAIL midreset_status: got pulse=%b count=%0d busy=%b, required 0 0 1",
                     event_pulse, event_count, busy);
        end
        exp_cnt = '0;
        @(negedge clk);
`ifdef KEY_POLL_IRQ_EN
        exp_q.push_back(TXN_MASK);
`endif
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (event_count !== exp_cnt) begin
            failures++;
            $display("FAIL midreset_no_event: got count %0d, required %0d", event_count, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_periodic_poll();
        test_capture();
        test_count_wrap();
        test_random_polls();
        test_enable_drop();
        test_irq();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0 || ev_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d bus and %0d event items pending, required 0",
                     exp_q.size(), ev_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_event_poller.md
# key_event_poller

Avalon-MM initiator that services the push-button PIO responder. It periodically reads the PIO edge-capture register, clears it when set, and converts each captured falling edge into a single-cycle `event_pulse` and a running event count. This lets fabric logic consume key presses directly, without a CPU or interrupt handler.

## Interface

Parameters:
- `POLL_INTERVAL`, default 50000: idle cycles between polls; legal range ≥ 1.
- `CNT_W`, default 16: width of `event_count`.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  polling enable; low holds the block in IDLE with the timer cleared.
- `irq`  in  1  PIO interrupt line; used only with `KEY_POLL_IRQ_EN`.
- `avm_address`  out  2  PIO register address.
- `avm_chipselect`  out  1  bus access strobe.
- `avm_write_n`  out  1  active-low write.
- `avm_writedata`  out  32  write data.
- `avm_readdata`  in  32  PIO registered read data; fixed read latency of 1 cycle.
- `event_pulse`  out  1  one-cycle pulse per serviced edge capture.
- `event_count`  out  CNT_W  number of serviced captures; wraps modulo 2^CNT_W.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation

Reset values:
- `avm_address` = 0, `avm_chipselect` = 0, `avm_write_n` = 1, `avm_writedata` = 0.
- `event_pulse` = 0, `event_count` = 0, `busy` = 1, timer = 0.
- All outputs are registered.

States:
- INIT (with macro) → IDLE; without the macro, reset exits directly to IDLE.
- IDLE: bus at its idle values.
  - Timer increments while `enable` = 1.
  - When timer = POLL_INTERVAL−1 and `enable` = 1: timer clears and the block goes to RD.
  - `enable` = 0: timer is held at 0.
- RD (1 cycle): drive `avm_address` = 3, `avm_chipselect` = 1, `avm_write_n` = 1. → CAP.
- CAP (1 cycle): bus idle; sample `avm_readdata[0]`.
  - Bit = 1 → CLR.
  - Bit = 0 → IDLE.
- CLR (1 cycle): drive `avm_address` = 3, `avm_chipselect` = 1, `avm_write_n` = 0, `avm_writedata` = 0. → IDLE.
  - `event_pulse` = 1 during the first IDLE cycle after CLR.
  - `event_count` increments on the same clock edge that raises `event_pulse`.
- `enable` falling in RD, CAP or CLR does not abort; the sequence completes, then the block holds in IDLE.

Boundary conditions:
- An edge captured by the PIO between the RD sample and the CLR write is lost. The PIO gives the clear priority over a simultaneous edge. This loss is accepted behaviour.
- Only `avm_readdata[0]` is evaluated; bits 31:1 are ignored.
- `event_count` wraps from 2^CNT_W−1 to 0 with no flag.
- Asynchronous reset mid-sequence:
  - All outputs return to reset values immediately.
  - No pending event is reported.
  - INIT re-runs when the macro is enabled.

## Timing

- Poll period with no capture: POLL_INTERVAL + 2 cycles (IDLE count + RD + CAP).
- Poll period with a capture: POLL_INTERVAL + 3 cycles.
- Bus accesses are exactly one cycle; `avm_chipselect` is never high in two consecutive cycles.
- Worst-case latency from the PIO setting edge_capture to `event_pulse`: POLL_INTERVAL + 4 cycles (`enable` held high).
- `busy` deasserts in the same cycle the state enters IDLE.

## Configuration

Macro `KEY_POLL_IRQ_EN`.

When defined:
- After reset, INIT performs one write: `avm_address` = 2, `avm_writedata` = 1, `avm_chipselect` = 1, `avm_write_n` = 0, then goes to IDLE.
- In IDLE with `enable` = 1, `irq` = 1 triggers RD immediately and clears the timer, regardless of the timer value.

When not defined:
- No INIT state and no mask write.
- `irq` is ignored; polling is purely timer-driven.

## Test plan

- Reset, then `enable` = 1, POLL_INTERVAL = 4, PIO readdata[0] held 0:
  - read strobes on address 3 every 6 cycles;
  - no write strobes; `event_pulse` stays 0; `event_count` stays 0.
- Set PIO capture bit = 1 once:
  - exactly one write to address 3 with data 0, two cycles after the read strobe;
  - `event_pulse` high for 1 cycle; `event_count` = 1;
  - the next poll reads 0.
- CNT_W = 2, 5 captures → `event_count` sequence 1, 2, 3, 0, 1.
- `enable` dropped during RD → CAP and CLR still complete; afterwards no read strobes while `enable` = 0; timer restarts from 0 when `enable` returns high.
- Assert `reset_n` low during CLR → all bus outputs idle asynchronously; `event_pulse` = 0; `event_count` = 0.
- With `KEY_POLL_IRQ_EN`, POLL_INTERVAL = 1000:
  - the first bus access is a write of 1 to address 2;
  - `irq` asserted at timer = 10 → read of address 3 in the next cycle.
